// File: rtl/capture_pkg.sv
// Shared types and helpers for the capture buffer: FSM state encoding,
// address-width helper and the byte-split width used when draining samples.
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    FETCH   = 3'd2,
    SEND_HI = 3'd3,
    SEND_LO = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Samples leave the block as two bytes, high byte first.
  localparam int BYTE_W = 8;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, one read port with a
// registered, enable-gated read so the output doubles as the sample register.
module capture_ram
  import capture_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 1024,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/capture_buffer.sv
// Trigger-driven record capture into RAM, drained to the host as a byte stream.
// Optional pretrigger ring-buffer mode is enabled by defining CAPTURE_PRETRIG_EN.
module capture_buffer
  import capture_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int DEPTH     = 1024,
  parameter int PRE_DEPTH = 256
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_response_valid,
  input  logic [DATA_W-1:0] i_sample_data,
  input  logic              i_TRIGGER,
  input  logic              i_tx_ready,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  output logic              o_TRANSFER_DONE,
  output logic              o_busy
);

  localparam int ADDR_W = addr_w(DEPTH);
`ifdef CAPTURE_PRETRIG_EN
  localparam int CAP_LEN = DEPTH - PRE_DEPTH;
  localparam logic [ADDR_W-1:0] PRE_FULL = ADDR_W'(PRE_DEPTH);
`else
  localparam int CAP_LEN = DEPTH;
`endif
  localparam logic [ADDR_W-1:0] CAP_LAST   = ADDR_W'(CAP_LEN - 1);
  localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(DEPTH - 1);

  if (DATA_W < 1 || DATA_W > 2 * BYTE_W) begin : g_bad_data_w
    $error("capture_buffer: DATA_W must be in 1..16");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("capture_buffer: DEPTH must be a power of two >= 4");
  end
  if (PRE_DEPTH < 1 || PRE_DEPTH >= DEPTH) begin : g_bad_pre_depth
    $error("capture_buffer: PRE_DEPTH must be in 1..DEPTH-1");
  end

  state_t              state_reg, state_next;
  logic                trig_prev_reg;
  logic [ADDR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0]   cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W-1:0]   drain_reg, drain_next;
`ifdef CAPTURE_PRETRIG_EN
  logic [ADDR_W-1:0]   pre_cnt_reg, pre_cnt_next;
`endif

  logic                trig_edge;
  logic                ram_we;
  logic                ram_re;
  logic [DATA_W-1:0]   ram_q;
  logic [2*BYTE_W-1:0] sample_wide;
  logic [ADDR_W-1:0]   drain_start;

  assign trig_edge   = i_TRIGGER & ~trig_prev_reg;
  assign sample_wide = (2*BYTE_W)'(ram_q);

  // The oldest sample in the ring sits at the slot the next write would use.
`ifdef CAPTURE_PRETRIG_EN
  assign drain_start = wr_ptr_reg + 1'b1;
`else
  assign drain_start = '0;
`endif

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (i_clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_reg),
    .wr_data (i_sample_data),
    .rd_en   (ram_re),
    .rd_addr (rd_ptr_reg),
    .rd_data (ram_q)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg     <= IDLE;
      trig_prev_reg <= 1'b0;
      wr_ptr_reg    <= '0;
      cnt_reg       <= '0;
      rd_ptr_reg    <= '0;
      drain_reg     <= '0;
`ifdef CAPTURE_PRETRIG_EN
      pre_cnt_reg   <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      trig_prev_reg <= i_TRIGGER;
      wr_ptr_reg    <= wr_ptr_next;
      cnt_reg       <= cnt_next;
      rd_ptr_reg    <= rd_ptr_next;
      drain_reg     <= drain_next;
`ifdef CAPTURE_PRETRIG_EN
      pre_cnt_reg   <= pre_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg;
    cnt_next        = cnt_reg;
    rd_ptr_next     = rd_ptr_reg;
    drain_next      = drain_reg;
`ifdef CAPTURE_PRETRIG_EN
    pre_cnt_next    = pre_cnt_reg;
`endif
    ram_we          = 1'b0;
    ram_re          = 1'b0;
    o_tx_valid      = 1'b0;
    o_tx_data       = '0;
    o_TRANSFER_DONE = 1'b0;
    o_busy          = (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
`ifdef CAPTURE_PRETRIG_EN
        if (trig_edge && pre_cnt_reg == PRE_FULL) begin
          cnt_next   = '0;
          drain_next = '0;
          state_next = CAPTURE;
        end else if (i_response_valid) begin
          ram_we      = 1'b1;
          wr_ptr_next = wr_ptr_reg + 1'b1;
          if (pre_cnt_reg != PRE_FULL) begin
            pre_cnt_next = pre_cnt_reg + 1'b1;
          end
        end
`else
        if (trig_edge) begin
          wr_ptr_next = '0;
          cnt_next    = '0;
          drain_next  = '0;
          state_next  = CAPTURE;
        end
`endif
      end

      CAPTURE: begin
        if (i_response_valid) begin
          ram_we      = 1'b1;
          wr_ptr_next = wr_ptr_reg + 1'b1;
          cnt_next    = cnt_reg + 1'b1;
          if (cnt_reg == CAP_LAST) begin
            rd_ptr_next = drain_start;
            state_next  = FETCH;
          end
        end
      end

      FETCH: begin
        ram_re     = 1'b1;
        state_next = SEND_HI;
      end

      SEND_HI: begin
        o_tx_valid = 1'b1;
        o_tx_data  = sample_wide[2*BYTE_W-1:BYTE_W];
        if (i_tx_ready) begin
          state_next = SEND_LO;
        end
      end

      SEND_LO: begin
        o_tx_valid = 1'b1;
        o_tx_data  = sample_wide[BYTE_W-1:0];
        if (i_tx_ready) begin
          drain_next = drain_reg + 1'b1;
          if (drain_reg == DRAIN_LAST) begin
            state_next = DONE;
          end else begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
            state_next  = FETCH;
          end
        end
      end

      DONE: begin
        o_TRANSFER_DONE = 1'b1;
        state_next      = IDLE;
`ifdef CAPTURE_PRETRIG_EN
        pre_cnt_next    = '0;
`endif
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_capture_buffer.sv
// Randomized self-checking bench for capture_buffer (DEPTH=8, PRE_DEPTH=3);
// the reference model also covers the CAPTURE_PRETRIG_EN build.
module tb_capture_buffer;

  localparam int DATA_W    = 12;
  localparam int DEPTH     = 8;
  localparam int PRE_DEPTH = 3;

  logic              i_clk;
  logic              i_reset;
  logic              i_response_valid;
  logic [DATA_W-1:0] i_sample_data;
  logic              i_TRIGGER;
  logic              i_tx_ready;
  logic              o_tx_valid;
  logic [7:0]        o_tx_data;
  logic              o_TRANSFER_DONE;
  logic              o_busy;

  capture_buffer #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .PRE_DEPTH (PRE_DEPTH)
  ) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_response_valid (i_response_valid),
    .i_sample_data    (i_sample_data),
    .i_TRIGGER        (i_TRIGGER),
    .i_tx_ready       (i_tx_ready),
    .o_tx_valid       (o_tx_valid),
    .o_tx_data        (o_tx_data),
    .o_TRANSFER_DONE  (o_TRANSFER_DONE),
    .o_busy           (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rx[$];
  logic [11:0] hist[$];
  int          done_cnt = 0;
  logic        pend = 1'b0;
  logic [7:0]  pend_data = '0;
  logic        s_valid, s_done, s_busy;
  logic [7:0]  s_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: observe outputs at the falling edge, then step past the rising edge.
  task automatic cycle();
    @(negedge i_clk);
    if (pend) begin
      check("hold_valid", 32'(o_tx_valid), 32'd1);
      check("hold_data", 32'(o_tx_data), 32'(pend_data));
    end
    if (o_tx_valid && i_tx_ready && !i_reset) rx.push_back(o_tx_data);
    if (o_TRANSFER_DONE) done_cnt++;
    pend      = o_tx_valid && !i_tx_ready && !i_reset;
    pend_data = o_tx_data;
    s_valid   = o_tx_valid;
    s_data    = o_tx_data;
    s_done    = o_TRANSFER_DONE;
    s_busy    = o_busy;
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_record(input logic [11:0] base, input int n_idle, input int valid_pct,
                            input int ready_pct, input bit hold, input int abort_after);
    logic [11:0] exp_q[$];
    logic [7:0]  eb[$];
    logic [11:0] s;
    int          need_post;
    int          got_post;
    int          bound;

    rx.delete();
    done_cnt = 0;
    i_TRIGGER = 1'b0; i_response_valid = 1'b0; i_tx_ready = 1'b0;
    cycle();
    for (int i = 0; i < n_idle; i++) begin
      s = base - 12'(n_idle) + 12'(i);
      i_response_valid = 1'b1; i_sample_data = s;
      cycle();
      hist.push_back(s);
    end
    // Trigger edge cycle: the sample offered here must not be recorded.
    i_TRIGGER = 1'b1; i_response_valid = 1'b1; i_sample_data = 12'hABC;
    cycle();
`ifdef CAPTURE_PRETRIG_EN
    for (int i = hist.size() - PRE_DEPTH; i < hist.size(); i++) exp_q.push_back(hist[i]);
    need_post = DEPTH - PRE_DEPTH;
`else
    need_post = DEPTH;
`endif
    s = base; got_post = 0; bound = 0;
    while (got_post < need_post && bound < 500) begin
      i_TRIGGER        = hold ? 1'b1 : 1'($urandom_range(0, 1));
      i_response_valid = ($urandom_range(0, 99) < valid_pct);
      i_tx_ready       = 1'($urandom_range(0, 1));
      i_sample_data    = i_response_valid ? s : 12'($urandom);
      cycle();
      if (i_response_valid) begin
        exp_q.push_back(s);
        s = s + 12'd1;
        got_post++;
      end
      bound++;
    end
    foreach (exp_q[k]) begin
      eb.push_back(8'(exp_q[k] >> 8));
      eb.push_back(8'(exp_q[k] & 12'h0FF));
    end

    bound = 0;
    while (done_cnt == 0 && bound < 1000) begin
      if (abort_after > 0 && rx.size() >= abort_after) break;
      if (rx.size() < 2 * DEPTH) begin
        i_TRIGGER        = hold ? 1'b1 : 1'($urandom_range(0, 1));
        i_response_valid = 1'($urandom_range(0, 1));
        i_sample_data    = 12'($urandom);
        i_tx_ready       = ($urandom_range(0, 99) < ready_pct);
      end else begin
        i_TRIGGER = hold; i_response_valid = 1'b0; i_tx_ready = 1'b0;
      end
      cycle();
      bound++;
    end

    if (abort_after > 0) begin
      i_tx_ready = 1'b0; i_TRIGGER = 1'b0; i_response_valid = 1'b0; i_reset = 1'b1;
      cycle();
      i_reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
        cycle();
        check("abort_valid", 32'(s_valid), 32'd0);
        check("abort_busy", 32'(s_busy), 32'd0);
      end
      check("abort_done", 32'(done_cnt), 32'd0);
      check("abort_nbytes", 32'(rx.size()), 32'(abort_after));
      for (int i = 0; i < abort_after && i < rx.size(); i++) check("abort_byte", 32'(rx[i]), 32'(eb[i]));
      hist.delete();
      $display("record base=0x%03h aborted after %0d bytes", base, rx.size());
      return;
    end

    check("done_once", 32'(done_cnt), 32'd1);
    hist.delete();
    i_response_valid = 1'b0;
    cycle();
    check("busy_after_done", 32'(s_busy), 32'd0);
    check("done_single", 32'(s_done), 32'd0);
    check("nbytes", 32'(rx.size()), 32'(eb.size()));
    for (int i = 0; i < eb.size() && i < rx.size(); i++) check("byte", 32'(rx[i]), 32'(eb[i]));
    if (hold) begin
      for (int i = 0; i < 6; i++) begin
        i_TRIGGER = 1'b1; i_response_valid = 1'b1; i_sample_data = base + 12'h40 + 12'(i);
        cycle();
        hist.push_back(i_sample_data);
        check("no_retrigger", 32'(s_busy), 32'd0);
      end
    end
    $display("record base=0x%03h hold=%0d bytes=%0d done=%0d", base, hold, rx.size(), done_cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_response_valid = 1'b0; i_sample_data = '0;
    i_TRIGGER = 1'b0; i_tx_ready = 1'b0;
    @(posedge i_clk); #1;
    cycle(); cycle(); cycle();
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_data", 32'(s_data), 32'd0);
    check("rst_done", 32'(s_done), 32'd0);
    check("rst_busy", 32'(s_busy), 32'd0);
    i_reset = 1'b0;
    $display("reset released");

    for (int i = 0; i < 16; i++) begin
      i_response_valid = 1'b1; i_sample_data = 12'(i); i_tx_ready = 1'($urandom_range(0, 1));
      cycle();
      hist.push_back(12'(i));
      check("idle_busy", 32'(s_busy), 32'd0);
      check("idle_valid", 32'(s_valid), 32'd0);
      check("idle_done", 32'(s_done), 32'd0);
    end
    $display("idle stream of 16 samples done");

    run_record(12'h5DD, 3, 100, 100, 1'b0, 0);
    run_record(12'h5DD, 3, 100, 50, 1'b0, 0);
    run_record(12'h2A0, 3, 70, 60, 1'b1, 0);
    run_record(12'h7F0, 3, 60, 70, 1'b0, 0);
    run_record(12'h300, 3, 80, 100, 1'b0, 5);
    run_record(12'h400, 3, 80, 80, 1'b0, 0);
    run_record(12'h106, 6, 100, 100, 1'b0, 0);
`ifdef CAPTURE_PRETRIG_EN
    for (int i = 0; i < 2; i++) begin
      i_TRIGGER = 1'b0; i_response_valid = 1'b1; i_sample_data = 12'h880 + 12'(i);
      cycle();
      hist.push_back(i_sample_data);
    end
    for (int i = 0; i < 4; i++) begin
      i_TRIGGER = 1'b1; i_response_valid = 1'b0;
      cycle();
      check("early_trig_ignored", 32'(s_busy), 32'd0);
    end
    run_record(12'h900, 2, 90, 80, 1'b0, 0);
`endif
    for (int r = 0; r < 4; r++) begin
      run_record(12'($urandom), 3 + r, $urandom_range(50, 100), $urandom_range(30, 100),
                 1'($urandom_range(0, 1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
